fetch_controller: RTL



---
 rtl/fetch_controller.sv | 70 +++++++
 1 files changed

// File: rtl/fetch_controller.sv
// Fetch stage: owns the PC, drives the combinational instruction memory and
// presents each fetched word to decode through a one-entry valid/ready stage.
module fetch_controller #(
  parameter logic [9:0] START_ADDR  = 10'd0,
  parameter logic [2:0] HALT_OPCODE = 3'b111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [9:0]  imem_addr,
  input  logic [15:0] imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_out,
  output logic [9:0]  pc_out,
  input  logic        redirect_valid,
  input  logic [9:0]  redirect_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t     state;
  logic [9:0] pc;
  logic       slot_free;
  logic       fetch;
  logic       redirect_take;

  assign slot_free     = !instr_valid | instr_ready;
  assign fetch         = (state == RUN) & slot_free & !redirect_valid;
  // Redirects are meaningless before the first start.
  assign redirect_take = redirect_valid & (state != IDLE);
  assign imem_addr     = pc;
  assign halted        = (state == HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_ADDR;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
      fetch_count <= '0;
    end else begin
      if (redirect_take) begin
        instr_valid <= 1'b0;
        pc          <= redirect_pc;
        state       <= RUN;
      end else if (fetch) begin
        instr_out   <= imem_data;
        pc_out      <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + 10'd1;
        if (fetch_count != '1)
          fetch_count <= fetch_count + 16'd1;
        if (imem_data[15:13] == HALT_OPCODE)
          state <= HALTED;
      end else begin
        if (instr_valid & instr_ready)
          instr_valid <= 1'b0;
        if (start && state != RUN) begin
          state <= RUN;
          pc    <= START_ADDR;
        end
      end
    end
  end

endmodule
